delay_meas_ctrl: RTL

- Sequencer for the edge-to-edge delay timer.
- On request it drives the stimulus line, which feeds the timer's start input and the device under test. It waits for the timer's result handshake, with a timeout, and repeats for 2^RUNS_LOG2 runs.
- Accumulates min, max and sum, then reports the average with a one-cycle done pulse.
- Sits between the host/control logic and the timer.

---
 rtl/delay_meas_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/delay_meas_ctrl.sv
// delay_meas_ctrl: sequences stim pulses for an edge-to-edge delay timer and reports min/max/average of 2^RUNS_LOG2 runs
// Ports: clk, rst (async, active-high); go/abort control; meas_ready/meas_value timer result handshake;
// stim timer start line; busy/done status; avg/min_val/max_val statistics; n_timeout/error lost-run reporting.
module delay_meas_ctrl #(
  parameter int CNT_W     = 16,
  parameter int RUNS_LOG2 = 4,
  parameter int PULSE_LEN = 8,
  parameter int TIMEOUT   = 32768,
  parameter int GAP_LEN   = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic                 abort,
  input  logic                 meas_ready,
  input  logic [CNT_W-1:0]     meas_value,
  output logic                 stim,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     avg,
  output logic [CNT_W-1:0]     min_val,
  output logic [CNT_W-1:0]     max_val,
  output logic [RUNS_LOG2:0]   n_timeout,
  output logic                 error
);
  localparam int SW = CNT_W + RUNS_LOG2;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int PW = $clog2((PULSE_LEN > GAP_LEN ? PULSE_LEN : GAP_LEN) + 1);
  typedef enum logic [2:0] {IDLE, PULSE, WAIT, GAP, FINISH} state_t;
  state_t               state;
  logic [SW-1:0]        sum;
  logic [WW-1:0]        wcnt;
  logic [PW-1:0]        pcnt;
  logic [RUNS_LOG2-1:0] run_cnt;
  logic                 got;
  logic                 acc;
  logic                 tmo;
  logic                 pend;
  logic                 gend;
  // only the first strobe of a run is taken; got marks a run already answered during PULSE
  assign acc  = meas_ready && !abort && (state == WAIT || (state == PULSE && !got));
  assign tmo  = state == WAIT && wcnt == WW'(TIMEOUT - 1);
  assign pend = pcnt == PW'(PULSE_LEN - 1);
  assign gend = pcnt == PW'(GAP_LEN - 1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      stim      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      avg       <= '0;
      min_val   <= '1;
      max_val   <= '0;
      n_timeout <= '0;
      error     <= 1'b0;
      sum       <= '0;
      wcnt      <= '0;
      pcnt      <= '0;
      run_cnt   <= '0;
      got       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort && state != IDLE) begin
        state <= IDLE;
        stim  <= 1'b0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: if (go) begin
            sum       <= '0;
            min_val   <= '1;
            max_val   <= '0;
            n_timeout <= '0;
            error     <= 1'b0;
            run_cnt   <= '0;
            wcnt      <= '0;
            pcnt      <= '0;
            got       <= 1'b0;
            stim      <= 1'b1;
            busy      <= 1'b1;
            state     <= PULSE;
          end
          PULSE: begin
            wcnt <= wcnt + 1'b1;
            pcnt <= pend ? '0 : pcnt + 1'b1;
            if (acc) got <= 1'b1;
            if (pend) begin
              stim  <= 1'b0;
              state <= (got || acc) ? GAP : WAIT;
            end
          end
          WAIT: begin
            wcnt <= wcnt + 1'b1;
            if (acc || tmo) state <= GAP;
            // a strobe landing on the timeout cycle still counts as a valid run
            if (!acc && tmo) n_timeout <= n_timeout + 1'b1;
          end
          GAP: begin
            pcnt <= gend ? '0 : pcnt + 1'b1;
            if (gend) begin
              if (&run_cnt) state <= FINISH;
              else begin
                run_cnt <= run_cnt + 1'b1;
                wcnt    <= '0;
                got     <= 1'b0;
                stim    <= 1'b1;
                state   <= PULSE;
              end
            end
          end
          FINISH: begin
            avg   <= |n_timeout ? '1 : sum[RUNS_LOG2 +: CNT_W];
            error <= |n_timeout;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (acc) begin
        sum     <= sum + SW'(meas_value);
        min_val <= meas_value < min_val ? meas_value : min_val;
        max_val <= meas_value > max_val ? meas_value : max_val;
      end
    end
  end
endmodule
